// File: rtl/reorder_buffer_pkg.sv
// Shared sizing and entry layout for the 2-wide in-order retirement buffer.
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE = 32;
  localparam int unsigned WIDTH    = 2;
  localparam int unsigned PRF_SIZE = 64;
  localparam int unsigned ARF_SIZE = 32;

  localparam int unsigned PT_W  = $clog2(PRF_SIZE);
  localparam int unsigned AR_W  = $clog2(ARF_SIZE);
  localparam int unsigned RI_W  = $clog2(ROB_SIZE);
  localparam int unsigned CNT_W = RI_W + 1;
  localparam int unsigned FS_W  = $clog2(WIDTH + 1);

  typedef struct packed {
    logic            valid;
    logic            complete;
    logic            mispred;
    logic [AR_W-1:0] arch_reg;
    logic [PT_W-1:0] T;
    logic [PT_W-1:0] T_old;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / complete / retire bundle between the core pipeline and the ROB.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic [WIDTH-1:0]           dispatch_valid;
  logic [WIDTH-1:0][AR_W-1:0] dispatch_arch_reg;
  logic [WIDTH-1:0][PT_W-1:0] dispatch_T;
  logic [WIDTH-1:0][PT_W-1:0] dispatch_T_old;
  logic [WIDTH-1:0][RI_W-1:0] dispatch_rob_idx;
  logic [FS_W-1:0]            free_slots;
  logic [WIDTH-1:0]           complete_en;
  logic [WIDTH-1:0][RI_W-1:0] complete_rob_idx;
  logic [WIDTH-1:0]           complete_mispred;
  logic [WIDTH-1:0]           retire_en;
  logic [WIDTH-1:0][PT_W-1:0] retired_tags;
  logic [WIDTH-1:0][PT_W-1:0] retire_T;
  logic [WIDTH-1:0][AR_W-1:0] retire_arch_reg;
  logic                       rollback_en;

  modport master (
    output dispatch_valid, dispatch_arch_reg, dispatch_T, dispatch_T_old,
    output complete_en, complete_rob_idx, complete_mispred,
    input  dispatch_rob_idx, free_slots,
    input  retire_en, retired_tags, retire_T, retire_arch_reg, rollback_en
  );

  modport slave (
    input  dispatch_valid, dispatch_arch_reg, dispatch_T, dispatch_T_old,
    input  complete_en, complete_rob_idx, complete_mispred,
    output dispatch_rob_idx, free_slots,
    output retire_en, retired_tags, retire_T, retire_arch_reg, rollback_en
  );

endinterface

// File: rtl/reorder_buffer_retire_select.sv
// In-order retire lane selection: a lane retires only behind retiring lanes,
// and a mispredicted entry retires itself but blocks every younger lane.
module reorder_buffer_retire_select
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned LANES = WIDTH
) (
  input  rob_entry_t                     entries_i [LANES],
  output logic [LANES-1:0]               retire_en_o,
  output logic                           rollback_o,
  output logic [$clog2(LANES+1)-1:0]     num_ret_o
);

  logic chain;

  always_comb begin
    retire_en_o = '0;
    rollback_o  = 1'b0;
    num_ret_o   = '0;
    chain       = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      retire_en_o[i] = chain && entries_i[i].valid && entries_i[i].complete;
      if (retire_en_o[i] && entries_i[i].mispred) rollback_o = 1'b1;
      chain     = retire_en_o[i] && !entries_i[i].mispred;
      num_ret_o = num_ret_o + ($clog2(LANES+1))'(retire_en_o[i]);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: entry array, head/tail/count and flush-at-retire handling.
// Retire outputs are combinational from registered state.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  reorder_buffer_if.slave  rob_io
);

  rob_entry_t       entries_q [ROB_SIZE];
  rob_entry_t       entries_d [ROB_SIZE];
  logic [RI_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] space;
  logic [FS_W-1:0]  free_slots;
  logic [WIDTH-1:0] accept;
  logic [FS_W-1:0]  num_acc, num_ret;
  logic [WIDTH-1:0] retire_en;
  logic             rollback;
  rob_entry_t       head_entries [WIDTH];

  // Free space comes from registered count only; same-cycle retires do not help.
  always_comb begin
    space      = CNT_W'(ROB_SIZE) - count_q;
    free_slots = (space < CNT_W'(WIDTH)) ? FS_W'(space) : FS_W'(WIDTH);
    accept     = '0;
    num_acc    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      accept[i] = rob_io.dispatch_valid[i] && (FS_W'(i) < free_slots);
      num_acc   = num_acc + FS_W'(accept[i]);
      head_entries[i] = entries_q[head_q + RI_W'(i)];
    end
  end

  reorder_buffer_retire_select #(.LANES(WIDTH)) u_retire_select (
    .entries_i   (head_entries),
    .retire_en_o (retire_en),
    .rollback_o  (rollback),
    .num_ret_o   (num_ret)
  );

  always_comb begin
    rob_io.free_slots       = free_slots;
    rob_io.retire_en        = retire_en;
    rob_io.rollback_en      = rollback;
    rob_io.dispatch_rob_idx = '0;
    rob_io.retired_tags     = '0;
    rob_io.retire_T         = '0;
    rob_io.retire_arch_reg  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      rob_io.dispatch_rob_idx[i] = tail_q + RI_W'(i);
      rob_io.retired_tags[i]     = head_entries[i].T_old;
      rob_io.retire_T[i]         = head_entries[i].T;
      rob_io.retire_arch_reg[i]  = head_entries[i].arch_reg;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q + RI_W'(num_ret);
    tail_d    = tail_q + RI_W'(num_acc);
    count_d   = count_q + CNT_W'(num_acc) - CNT_W'(num_ret);
    if (rollback) begin
      // Flush: younger work, this cycle's dispatch and completes are all dropped.
      for (int unsigned e = 0; e < ROB_SIZE; e++) entries_d[e].valid = 1'b0;
      tail_d  = head_d;
      count_d = '0;
    end else begin
      for (int unsigned c = 0; c < WIDTH; c++) begin
        if (rob_io.complete_en[c] && entries_q[rob_io.complete_rob_idx[c]].valid) begin
          entries_d[rob_io.complete_rob_idx[c]].complete = 1'b1;
          entries_d[rob_io.complete_rob_idx[c]].mispred  =
            entries_q[rob_io.complete_rob_idx[c]].mispred | rob_io.complete_mispred[c];
        end
      end
      for (int unsigned r = 0; r < WIDTH; r++) begin
        if (retire_en[r]) entries_d[head_q + RI_W'(r)].valid = 1'b0;
      end
      for (int unsigned d = 0; d < WIDTH; d++) begin
        if (accept[d]) begin
          entries_d[tail_q + RI_W'(d)] = '{valid: 1'b1, complete: 1'b0, mispred: 1'b0,
                                           arch_reg: rob_io.dispatch_arch_reg[d],
                                           T: rob_io.dispatch_T[d],
                                           T_old: rob_io.dispatch_T_old[d]};
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned e = 0; e < ROB_SIZE; e++) entries_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: vector table plus multi-cycle corner sequences.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  reorder_buffer_if bus ();
  reorder_buffer dut (.clock(clock), .reset(reset), .rob_io(bus.slave));

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  typedef struct {
    logic [1:0] dv;
    logic [4:0] ar0, ar1;
    logic [5:0] t0, o0, t1, o1;
    logic [1:0] ce;
    logic [4:0] ci0, ci1;
    logic [1:0] cm;
    logic [1:0] e_free;
    logic [4:0] e_idx0;
    logic [1:0] e_ret;
    logic [5:0] e_rt0, e_rt1;
    logic       e_rb;
    logic [5:0] e_cnt;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input logic [1:0] dv, input logic [4:0] ar0, input logic [5:0] t0, o0,
                     input logic [4:0] ar1, input logic [5:0] t1, o1,
                     input logic [1:0] ce, input logic [4:0] ci0, ci1, input logic [1:0] cm,
                     input logic [1:0] e_free, input logic [4:0] e_idx0, input logic [1:0] e_ret,
                     input logic [5:0] e_rt0, e_rt1, input logic e_rb, input logic [5:0] e_cnt);
    vec_t v;
    v.dv = dv; v.ar0 = ar0; v.t0 = t0; v.o0 = o0; v.ar1 = ar1; v.t1 = t1; v.o1 = o1;
    v.ce = ce; v.ci0 = ci0; v.ci1 = ci1; v.cm = cm;
    v.e_free = e_free; v.e_idx0 = e_idx0; v.e_ret = e_ret;
    v.e_rt0 = e_rt0; v.e_rt1 = e_rt1; v.e_rb = e_rb; v.e_cnt = e_cnt;
    tv.push_back(v);
  endtask

  task automatic idle();
    bus.dispatch_valid    = '0;
    bus.dispatch_arch_reg = '0;
    bus.dispatch_T        = '0;
    bus.dispatch_T_old    = '0;
    bus.complete_en       = '0;
    bus.complete_rob_idx  = '0;
    bus.complete_mispred  = '0;
  endtask

  task automatic dispatch(input logic [1:0] dv, input logic [4:0] ar0, input logic [5:0] t0, o0,
                          input logic [4:0] ar1, input logic [5:0] t1, o1);
    bus.dispatch_valid       = dv;
    bus.dispatch_arch_reg[0] = ar0; bus.dispatch_T[0] = t0; bus.dispatch_T_old[0] = o0;
    bus.dispatch_arch_reg[1] = ar1; bus.dispatch_T[1] = t1; bus.dispatch_T_old[1] = o1;
  endtask

  task automatic complete(input logic [1:0] ce, input logic [4:0] ci0, ci1, input logic [1:0] cm);
    bus.complete_en         = ce;
    bus.complete_rob_idx[0] = ci0;
    bus.complete_rob_idx[1] = ci1;
    bus.complete_mispred    = cm;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();
    #1;
    chk("reset ret_en", bus.retire_en, 2'b00);
    chk("reset rollback", bus.rollback_en, 1'b0);
    chk("reset free", bus.free_slots, 2);
    chk("reset idx0", bus.dispatch_rob_idx[0], 0);
    chk("reset count", dut.count_q, 0);

    // dv ar0 t0 o0 ar1 t1 o1 | ce ci0 ci1 cm | free idx0 ret rt0 rt1 rb cnt
    add(2'b11, 3, 32, 1, 4, 33, 2,   0, 0, 0, 0,      2, 0, 2'b00, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0,     2'b11, 0, 1, 0,  2, 2, 2'b00, 0, 0, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      2, 2, 2'b11, 1, 2, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      2, 2, 2'b00, 0, 0, 0, 0);
    add(2'b11, 5, 34, 5, 6, 35, 6,   0, 0, 0, 0,      2, 2, 2'b00, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0,     2'b01, 3, 0, 0,  2, 4, 2'b00, 0, 0, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      2, 4, 2'b00, 0, 0, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     2'b01, 2, 0, 0,  2, 4, 2'b00, 0, 0, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      2, 4, 2'b11, 5, 6, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      2, 4, 2'b00, 0, 0, 0, 0);
    add(2'b11, 7, 36, 7, 8, 37, 8,   0, 0, 0, 0,      2, 4, 2'b00, 0, 0, 0, 0);
    add(2'b11, 9, 38, 9, 10, 39, 10, 0, 0, 0, 0,      2, 6, 2'b00, 0, 0, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     2'b11, 4, 5, 2'b10, 2, 8, 2'b00, 0, 0, 0, 4);
    add(2'b00, 0, 0, 0, 0, 0, 0,     2'b11, 6, 7, 0,  2, 8, 2'b11, 7, 8, 1, 4);
    add(2'b00, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      2, 6, 2'b00, 0, 0, 0, 0);
    add(2'b11, 11, 40, 11, 12, 41, 12, 0, 0, 0, 0,    2, 6, 2'b00, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0, 0,     2'b11, 6, 7, 2'b01, 2, 8, 2'b00, 0, 0, 0, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      2, 8, 2'b01, 11, 0, 1, 2);
    add(2'b00, 0, 0, 0, 0, 0, 0,     0, 0, 0, 0,      2, 7, 2'b00, 0, 0, 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      dispatch(tv[i].dv, tv[i].ar0, tv[i].t0, tv[i].o0, tv[i].ar1, tv[i].t1, tv[i].o1);
      complete(tv[i].ce, tv[i].ci0, tv[i].ci1, tv[i].cm);
      #1;
      chk($sformatf("v%0d free", i), bus.free_slots, tv[i].e_free);
      chk($sformatf("v%0d idx0", i), bus.dispatch_rob_idx[0], tv[i].e_idx0);
      chk($sformatf("v%0d ret_en", i), bus.retire_en, tv[i].e_ret);
      chk($sformatf("v%0d rollback", i), bus.rollback_en, tv[i].e_rb);
      chk($sformatf("v%0d count", i), dut.count_q, tv[i].e_cnt);
      if (tv[i].e_ret[0]) chk($sformatf("v%0d tag0", i), bus.retired_tags[0], tv[i].e_rt0);
      if (tv[i].e_ret[1]) chk($sformatf("v%0d tag1", i), bus.retired_tags[1], tv[i].e_rt1);
      step();
    end

    // Fill to full, then drop further dispatch; retire out of a full buffer.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      dispatch(2'b11, 5'(k), 6'(2*k), 6'(2*k), 5'(k), 6'(2*k+1), 6'(2*k+1));
      step();
    end
    chk("full free", bus.free_slots, 0);
    chk("full count", dut.count_q, 32);
    chk("full idx0", bus.dispatch_rob_idx[0], 0);
    chk("full ret_en", bus.retire_en, 2'b00);
    dispatch(2'b11, 1, 1, 1, 2, 2, 2);
    step();
    chk("full drop count", dut.count_q, 32);
    chk("full drop idx0", bus.dispatch_rob_idx[0], 0);
    complete(2'b01, 0, 0, 0);
    step();
    chk("full retire ret_en", bus.retire_en, 2'b01);
    chk("full retire tag0", bus.retired_tags[0], 0);
    chk("full retire free", bus.free_slots, 0);
    step();
    chk("31 count", dut.count_q, 31);
    chk("31 free", bus.free_slots, 1);
    complete(2'b01, 1, 0, 0);
    step();
    dispatch(2'b11, 7, 60, 40, 8, 61, 41);
    #1;
    chk("31 ret_en", bus.retire_en, 2'b01);
    chk("31 tag0", bus.retired_tags[0], 1);
    chk("31 free same", bus.free_slots, 1);
    step();
    chk("31 after count", dut.count_q, 31);
    chk("31 after idx0", bus.dispatch_rob_idx[0], 1);

    // Pointer wrap with out-of-order completion across the boundary.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      dispatch(2'b11, 1, 1, 1, 2, 2, 2);
      step();
      complete(2'b11, 5'(2*k), 5'(2*k+1), 0);
      step();
      chk($sformatf("adv%0d ret_en", k), bus.retire_en, 2'b11);
      step();
    end
    chk("wrap start count", dut.count_q, 0);
    dispatch(2'b11, 1, 10, 50, 2, 11, 51);
    #1;
    chk("wrap idx0 a", bus.dispatch_rob_idx[0], 30);
    chk("wrap idx1 a", bus.dispatch_rob_idx[1], 31);
    step();
    dispatch(2'b11, 3, 12, 52, 4, 13, 53);
    #1;
    chk("wrap idx0 b", bus.dispatch_rob_idx[0], 0);
    chk("wrap idx1 b", bus.dispatch_rob_idx[1], 1);
    step();
    complete(2'b11, 31, 1, 0);
    step();
    chk("wrap early ret_en", bus.retire_en, 2'b00);
    complete(2'b11, 0, 30, 0);
    step();
    chk("wrap r1 ret_en", bus.retire_en, 2'b11);
    chk("wrap r1 tag0", bus.retired_tags[0], 50);
    chk("wrap r1 tag1", bus.retired_tags[1], 51);
    chk("wrap r1 arch0", bus.retire_arch_reg[0], 1);
    chk("wrap r1 T1", bus.retire_T[1], 11);
    step();
    chk("wrap r2 ret_en", bus.retire_en, 2'b11);
    chk("wrap r2 tag0", bus.retired_tags[0], 52);
    chk("wrap r2 tag1", bus.retired_tags[1], 53);
    step();
    chk("wrap end ret_en", bus.retire_en, 2'b00);
    chk("wrap end count", dut.count_q, 0);
    chk("wrap end idx0", bus.dispatch_rob_idx[0], 2);

    // Asynchronous reset with live entries.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      dispatch(2'b11, 1, 20, 21, 2, 22, 23);
      step();
    end
    chk("pre-reset count", dut.count_q, 10);
    complete(2'b11, 0, 1, 0);
    step();
    chk("pre-reset ret_en", bus.retire_en, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("async reset ret_en", bus.retire_en, 2'b00);
    chk("async reset count", dut.count_q, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("post-reset free", bus.free_slots, 2);
    chk("post-reset idx0", bus.dispatch_rob_idx[0], 0);
    complete(2'b01, 0, 0, 0);
    step();
    dispatch(2'b11, 1, 24, 25, 2, 26, 27);
    step();
    chk("stale complete ret_en", bus.retire_en, 2'b00);
    chk("stale complete count", dut.count_q, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
